lfsr_rand_gen: RTL and testbench

Parametrised successor of the team's 8-bit seedable random number block. A maximal-length Fibonacci LFSR of configurable width can free-run or be seeded. It adds a request/valid interface that returns a uniformly distributed value in [0, range_max], using mask-and-reject sampling. It feeds game and test-pattern logic that needs bounded random values, and still exposes the raw LFSR state for legacy users.

---
 rtl/lfsr_rand_pkg.sv | 30 +++
 rtl/lfsr_rand_if.sv | 22 ++
 rtl/lfsr_rand_gen_core.sv | 25 ++
 rtl/lfsr_rand_gen.sv | 74 +++++++
 tb/tb_lfsr_rand_gen.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_rand_pkg.sv
// lfsr_rand_pkg: shared tap table, FSM state type and range-mask helper for the LFSR random generator
package lfsr_rand_pkg;

  typedef enum logic {IDLE, DRAW} state_t;

  // maximal-length Fibonacci tap masks, indexed by LFSR width; bit i set means lfsr[i] feeds the XOR
  localparam logic [31:0] TAPS [4:32] = '{
    32'h0000_000C, 32'h0000_0014, 32'h0000_0030, 32'h0000_0060,
    32'h0000_00B8, 32'h0000_0110, 32'h0000_0240, 32'h0000_0500,
    32'h0000_0829, 32'h0000_100D, 32'h0000_2015, 32'h0000_6000,
    32'h0000_D008, 32'h0001_2000, 32'h0002_0400, 32'h0004_0023,
    32'h0009_0000, 32'h0014_0000, 32'h0030_0000, 32'h0042_0000,
    32'h00E1_0000, 32'h0120_0000, 32'h0200_0023, 32'h0400_0013,
    32'h0900_0000, 32'h1400_0000, 32'h2000_0029, 32'h4800_0000,
    32'h8020_0003
  };

  // smallest 2^k-1 that covers r: smear the top set bit into every lower position
  function automatic logic [31:0] mask_ceil(input logic [31:0] r);
    logic [31:0] m;
    m = r;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_rand_if.sv
// lfsr_rand_if: seed/step control, bounded-draw request/result and raw state bundle
interface lfsr_rand_if #(parameter int WIDTH = 8);
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             en;
  logic             req;
  logic [WIDTH-1:0] range_max;
  logic             rnd_valid;
  logic [WIDTH-1:0] rnd_data;
  logic             busy;
  logic [WIDTH-1:0] randNum;

  modport master (
    output load, seed, en, req, range_max,
    input  rnd_valid, rnd_data, busy, randNum
  );

  modport slave (
    input  load, seed, en, req, range_max,
    output rnd_valid, rnd_data, busy, randNum
  );
endinterface

// File: rtl/lfsr_rand_gen_core.sv
// lfsr_core: Fibonacci LFSR register with seed load, zero-seed substitution and gated stepping
module lfsr_core #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {q[WIDTH-2:0], ^(q & TAPS)};

  // load beats step; an all-zero seed would lock the register, so it is replaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= DEFAULT_SEED;
    else if (load) q <= (seed == '0) ? DEFAULT_SEED : seed;
    else if (step) q <= nxt;
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: seedable maximal-length LFSR with bounded mask-and-reject random draws
module lfsr_rand_gen
  import lfsr_rand_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  lfsr_rand_if.slave  bus
);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rand_gen: WIDTH must be within 4..32");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("lfsr_rand_gen: DEFAULT_SEED must be nonzero");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_nxt, mask_q, rng_q, cand, data_q;
  logic             valid_q, step, start, accept;

  lfsr_core #(
    .WIDTH       (WIDTH),
    .TAPS        (WIDTH'(TAPS[WIDTH])),
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .load (bus.load),
    .seed (bus.seed),
    .step (step),
    .q    (lfsr_q),
    .nxt  (lfsr_nxt)
  );

  assign cand = lfsr_nxt & mask_q;

  // next state and step control; load aborts everything, and the LFSR holds on the req cycle
  always_comb begin
    start   = !bus.load && state_q == IDLE && bus.req;
    accept  = !bus.load && state_q == DRAW && cand <= rng_q;
    step    = state_q == DRAW || (bus.en && !bus.req);
    state_d = bus.load ? IDLE : start ? DRAW : accept ? IDLE : state_q;
  end

  // request FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // capture bound/mask on request start and register accepted results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      rng_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      mask_q  <= start ? WIDTH'(mask_ceil(32'(bus.range_max))) : mask_q;
      rng_q   <= start ? bus.range_max : rng_q;
      data_q  <= accept ? cand : data_q;
      valid_q <= accept;
    end
  end

  assign bus.busy      = state_q == DRAW;
  assign bus.rnd_valid = valid_q;
  assign bus.rnd_data  = data_q;
  assign bus.randNum   = lfsr_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen: directed and randomized checks of lfsr_rand_gen against an arithmetic reference model
module tb_lfsr_rand_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned m_lfsr;

  lfsr_rand_if #(.WIDTH(8)) bus ();

  lfsr_rand_gen #(.WIDTH(8), .DEFAULT_SEED(8'h01)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // x^8 LFSR model: double modulo 256, add parity of positions 7,5,4,3
  function automatic int unsigned ref_step(input int unsigned x);
    int unsigned ones;
    ones = (x >> 7) % 2 + (x >> 5) % 2 + (x >> 4) % 2 + (x >> 3) % 2;
    return (x * 2) % 256 + ones % 2;
  endfunction

  function automatic int unsigned ref_mask(input int unsigned r);
    int unsigned m;
    m = 0;
    while (m < r) m = m * 2 + 1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_seed(input int unsigned s);
    bus.load = 1'b1;
    bus.seed = 8'(s);
    tick();
    bus.load = 1'b0;
    m_lfsr = (s % 256 == 0) ? 1 : s % 256;
    chk("load_seed", bus.randNum, m_lfsr);
  endtask

  task automatic run_free(input int n);
    bus.en = 1'b1;
    repeat (n) begin
      tick();
      m_lfsr = ref_step(m_lfsr);
      chk("free_run", bus.randNum, m_lfsr);
    end
    bus.en = 1'b0;
  endtask

  // one bounded draw; busy/valid timing follows the model's own reject count
  task automatic do_req(input int unsigned r, output int unsigned got);
    int unsigned x, m;
    int k;
    x = m_lfsr;
    m = ref_mask(r);
    k = 0;
    do begin
      x = ref_step(x);
      k++;
    end while ((x & m) > r);
    bus.req = 1'b1;
    bus.range_max = 8'(r);
    bus.en = 1'($urandom);
    tick();
    bus.en = 1'b0;
    for (int j = 0; j < k; j++) begin
      bus.req = (j < k - 1) ? 1'($urandom) : 1'b0;
      bus.range_max = 8'($urandom);
      chk("busy_in_draw", bus.busy, 1);
      chk("no_valid_in_draw", bus.rnd_valid, 0);
      tick();
    end
    bus.req = 1'b0;
    chk("valid", bus.rnd_valid, 1);
    chk("data", bus.rnd_data, x & m);
    chk("idle_after", bus.busy, 0);
    chk("lfsr_after_draw", bus.randNum, x);
    m_lfsr = x;
    got = x & m;
  endtask

  initial begin
    int unsigned got;
    int distinct;
    bit seen [256];
    int hist [6];
    int unsigned v;
    bus.load = 1'b0;
    bus.seed = '0;
    bus.en = 1'b0;
    bus.req = 1'b0;
    bus.range_max = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_randNum", bus.randNum, 8'h01);
    chk("rst_valid", bus.rnd_valid, 0);
    chk("rst_data", bus.rnd_data, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_seed(1);
    run_free(4);
    chk("seq_end_11", bus.randNum, 8'h11);

    load_seed(1);
    distinct = 0;
    bus.en = 1'b1;
    for (int i = 0; i < 255; i++) begin
      tick();
      m_lfsr = ref_step(m_lfsr);
      chk("period_step", bus.randNum, m_lfsr);
      v = 32'(bus.randNum);
      if (!seen[v]) distinct++;
      seen[v] = 1'b1;
    end
    bus.en = 1'b0;
    chk("period_return", bus.randNum, 8'h01);
    chk("period_distinct", distinct, 255);
    chk("zero_never", seen[0], 0);

    load_seed(0);
    chk("zero_seed_default", bus.randNum, 8'h01);
    run_free(3);

    load_seed(1);
    do_req(0, got);
    chk("range0_data", bus.rnd_data, 0);
    tick();
    chk("valid_pulse", bus.rnd_valid, 0);
    chk("data_held", bus.rnd_data, 0);

    load_seed(1);
    do_req(5, got);
    chk("first_draw_2", bus.rnd_data, 2);
    for (int i = 0; i < 6; i++) hist[i] = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) run_free($urandom_range(1, 3));
      do_req(5, got);
      v = 32'(bus.rnd_data);
      if (v <= 5) hist[v]++;
    end
    for (int b = 0; b < 6; b++) chk("hist_uniform", (hist[b] >= 120 && hist[b] <= 220), 1);
    chk("hist_total", hist[0] + hist[1] + hist[2] + hist[3] + hist[4] + hist[5], 1000);

    for (int i = 0; i < 200; i++) begin
      case (i % 8)
        0: v = 255;
        1: v = 7;
        2: v = 15;
        3: v = 1;
        4: v = 128;
        default: v = $urandom_range(0, 255);
      endcase
      if ($urandom_range(0, 2) == 0) run_free($urandom_range(1, 4));
      do_req(v, got);
    end

    load_seed(8'h21);
    bus.req = 1'b1;
    bus.range_max = 8'd5;
    tick();
    bus.req = 1'b0;
    chk("abort_busy_before", bus.busy, 1);
    bus.load = 1'b1;
    bus.seed = 8'h5A;
    tick();
    bus.load = 1'b0;
    m_lfsr = 32'h5A;
    chk("abort_busy", bus.busy, 0);
    chk("abort_no_valid", bus.rnd_valid, 0);
    chk("abort_lfsr", bus.randNum, m_lfsr);
    tick();
    chk("abort_no_late_valid", bus.rnd_valid, 0);
    chk("abort_lfsr_held", bus.randNum, m_lfsr);

    bus.load = 1'b1;
    bus.req = 1'b1;
    bus.seed = 8'h33;
    bus.range_max = 8'd3;
    tick();
    bus.load = 1'b0;
    bus.req = 1'b0;
    m_lfsr = 32'h33;
    chk("load_req_busy", bus.busy, 0);
    chk("load_req_lfsr", bus.randNum, m_lfsr);
    tick();
    chk("load_req_no_valid", bus.rnd_valid, 0);

    do_req(255, got);
    chk("full_range_nonzero", (bus.rnd_data != 0), 1);
    bus.req = 1'b1;
    bus.range_max = 8'd5;
    tick();
    bus.req = 1'b0;
    chk("rst_mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_randNum", bus.randNum, 8'h01);
    chk("arst_busy", bus.busy, 0);
    chk("arst_valid", bus.rnd_valid, 0);
    chk("arst_data", bus.rnd_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
